// File: rtl/param_cnt_div.sv
// Up/down counter with programmable inclusive limit, wrap or one-shot halt, and a
// mod-DIV residue tracker with serial recompute, enabled by the CNT_DIV_CHK_EN macro.
module param_cnt_div #(
   parameter int WIDTH     = 16,
   parameter int DIV       = 3,
   parameter int LIMIT_RST = 300
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic             oneshot,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             done,
   output logic             ready,
   output logic             div_hit,
   output logic             div_valid,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_CALC = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] LIM_DEF = WIDTH'(LIMIT_RST);

`ifdef CNT_DIV_CHK_EN
   localparam state_t ST_RECALC = ST_CALC;
`else
   localparam state_t ST_RECALC = ST_RUN;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_out;
   logic             r_wrap;
   logic [WIDTH-1:0] w_lim;
   logic             w_step;
   logic             w_at_end;
   logic             w_wrap_step;

   assign w_lim       = (limit == '0) ? LIM_DEF : limit;
   assign w_step      = (r_state == ST_RUN) && en && !clr && !load;
   // Values above the limit count as "at the end" so the next up-step wraps.
   assign w_at_end    = dir ? (r_out >= w_lim) : (r_out == '0);
   assign w_wrap_step = w_step && w_at_end;

`ifdef CNT_DIV_CHK_EN
   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [7:0]      r_res;
   logic [IDXW-1:0] r_bit_idx;
   logic [7:0]      w_res_inc;
   logic [7:0]      w_res_dec;
   logic [8:0]      w_res_dbl;
   logic [7:0]      w_res_calc;

   assign w_res_inc  = (r_res == 8'(DIV - 1)) ? 8'd0 : r_res + 8'd1;
   assign w_res_dec  = (r_res == 8'd0) ? 8'(DIV - 1) : r_res - 8'd1;
   // 2r+bit stays below 2*DIV, so one conditional subtract reduces it.
   assign w_res_dbl  = {r_res, r_out[r_bit_idx]};
   assign w_res_calc = (w_res_dbl >= 9'(DIV)) ? 8'(w_res_dbl - 9'(DIV)) : w_res_dbl[7:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_res     <= '0;
         r_bit_idx <= '0;
      end else if (clr) begin
         r_res <= '0;
      end else if (load || (w_wrap_step && !oneshot && !dir)) begin
         r_res     <= '0;
         r_bit_idx <= IDXW'(WIDTH - 1);
      end else if (r_state == ST_CALC) begin
         r_res     <= w_res_calc;
         r_bit_idx <= r_bit_idx - IDXW'(1);
      end else if (w_step) begin
         if (!w_at_end)
            r_res <= dir ? w_res_inc : w_res_dec;
         else if (!oneshot)
            r_res <= '0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clr) begin
         w_state_nxt = ST_RUN;
      end else if (load) begin
         w_state_nxt = ST_RECALC;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_wrap_step) begin
                  if (oneshot)   w_state_nxt = ST_HALT;
                  else if (!dir) w_state_nxt = ST_RECALC;
               end
            end
`ifdef CNT_DIV_CHK_EN
            ST_CALC: if (r_bit_idx == '0) w_state_nxt = ST_RUN;
`else
            ST_CALC: w_state_nxt = ST_RUN;
`endif
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (clr) begin
            r_out <= '0;
         end else if (load) begin
            r_out <= load_val;
         end else if (w_step) begin
            if (!w_at_end) begin
               r_out <= dir ? r_out + WIDTH'(1) : r_out - WIDTH'(1);
            end else if (!oneshot) begin
               r_out  <= dir ? '0 : w_lim;
               r_wrap <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      done      = (r_state == ST_HALT);
      ready     = (r_state == ST_RUN);
      dbg_state = r_state;
`ifdef CNT_DIV_CHK_EN
      div_valid = (r_state != ST_CALC);
      div_hit   = (r_res == 8'd0);
`else
      div_valid = 1'b0;
      div_hit   = 1'b0;
`endif
   end

   assign out  = r_out;
   assign wrap = r_wrap;

endmodule

// File: tb/tb_param_cnt_div.sv
// Bench for param_cnt_div: directed scenarios plus random traffic against a
// behavioural model of the counter; follows the CNT_DIV_CHK_EN build setting.
`timescale 1ns/1ps
module tb_param_cnt_div;

   localparam int WIDTH     = 16;
   localparam int DIV       = 3;
   localparam int LIMIT_RST = 300;
   localparam int S_RUN = 0, S_CALC = 1, S_HALT = 2;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1, oneshot = 1'b0;
   logic [WIDTH-1:0] load_val = '0, limit = '0;
   logic [WIDTH-1:0] out;
   logic             wrap, done, ready, div_hit, div_valid;
   logic [1:0]       dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   int m_out   = 0;
   int m_state = S_RUN;
   int m_calc  = 0;
   bit m_wrap  = 1'b0;

   param_cnt_div #(.WIDTH(WIDTH), .DIV(DIV), .LIMIT_RST(LIMIT_RST)) dut (
      .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load(load), .load_val(load_val),
      .dir(dir), .oneshot(oneshot), .limit(limit), .out(out), .wrap(wrap),
      .done(done), .ready(ready), .div_hit(div_hit), .div_valid(div_valid),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic bit chk_on();
`ifdef CNT_DIV_CHK_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit exp_valid();
      return chk_on() && (m_state != S_CALC);
   endfunction

   function automatic bit exp_hit();
      return chk_on() && ((m_out % DIV) == 0);
   endfunction

   // div_hit is only meaningful outside CALC when the tracker exists.
   function automatic bit hit_known();
      return !chk_on() || (m_state != S_CALC);
   endfunction

   task automatic model_reset();
      m_out = 0; m_state = S_RUN; m_calc = 0; m_wrap = 1'b0;
   endtask

   task automatic model_step(input bit e, c, ld, input int lv, input bit d, os, input int lim);
      int l;
      l = (lim == 0) ? LIMIT_RST : lim;
      m_wrap = 1'b0;
      if (c) begin
         m_out = 0; m_state = S_RUN;
      end else if (ld) begin
         m_out = lv;
         m_state = chk_on() ? S_CALC : S_RUN;
         m_calc = WIDTH;
      end else if (m_state == S_CALC) begin
         m_calc--;
         if (m_calc == 0) m_state = S_RUN;
      end else if (m_state == S_RUN && e) begin
         if (d) begin
            if (m_out < l)  m_out++;
            else if (os)    m_state = S_HALT;
            else begin m_out = 0; m_wrap = 1'b1; end
         end else begin
            if (m_out > 0)  m_out--;
            else if (os)    m_state = S_HALT;
            else begin
               m_out = l; m_wrap = 1'b1;
               if (chk_on()) begin m_state = S_CALC; m_calc = WIDTH; end
            end
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle for sampling.
   task automatic cycle(input bit e, c, ld, input int lv, input bit d, os, input int lim);
      @(negedge clk);
      en = e; clr = c; load = ld; load_val = WIDTH'(lv);
      dir = d; oneshot = os; limit = WIDTH'(lim);
      @(posedge clk);
      model_step(e, c, ld, lv, d, os, lim);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out !== '0) begin n_fail++; $display("FAIL reset out: got %0d expected 0", out); end
      n_checks++; if (wrap !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset wrap/done: got %b/%b expected 0/0", wrap, done); end
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b expected 1", ready); end
      n_checks++; if (div_valid !== exp_valid() || div_hit !== exp_hit()) begin
         n_fail++; $display("FAIL reset div: got valid=%b hit=%b expected %b %b", div_valid, div_hit, exp_valid(), exp_hit());
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_count_up();
      int wraps = 0;
      int seen_bad = 0;
      cycle(0, 1, 0, 0, 1, 0, 0);
      for (int i = 1; i <= 301; i++) begin
         cycle(1, 0, 0, 0, 1, 0, 0);
         if (wrap === 1'b1) wraps++;
         if (out !== WIDTH'(i % 301)) seen_bad++;
         if (hit_known() && div_hit !== exp_hit()) seen_bad++;
      end
      n_checks++; if (seen_bad != 0) begin n_fail++; $display("FAIL count_up sequence: got %0d bad cycles expected 0", seen_bad); end
      n_checks++; if (wraps != 1) begin n_fail++; $display("FAIL count_up wraps: got %0d expected 1", wraps); end
      n_checks++; if (out !== '0) begin n_fail++; $display("FAIL count_up final out: got %0d expected 0", out); end
   endtask

   task automatic test_load();
      int bad = 0;
      cycle(0, 0, 1, 1000, 1, 0, 0);
      n_checks++; if (out !== WIDTH'(1000)) begin n_fail++; $display("FAIL load out: got %0d expected 1000", out); end
      n_checks++; if (ready !== (m_state == S_RUN)) begin n_fail++; $display("FAIL load ready: got %b expected %b", ready, m_state == S_RUN); end
      for (int i = 0; i < WIDTH; i++) begin
         if (div_valid !== exp_valid() || ready !== (m_state == S_RUN) || out !== WIDTH'(m_out)) bad++;
         cycle(1, 0, 0, 0, 1, 0, 0);
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL load calc window: got %0d bad cycles expected 0", bad); end
      n_checks++; if (div_hit !== exp_hit() || div_valid !== exp_valid()) begin
         n_fail++; $display("FAIL load residue: got hit=%b valid=%b expected %b %b", div_hit, div_valid, exp_hit(), exp_valid());
      end
      // load above limit: next up-step wraps
      cycle(0, 0, 1, 50, 1, 0, 20);
      while (m_state == S_CALC) cycle(0, 0, 0, 0, 1, 0, 20);
      cycle(1, 0, 0, 0, 1, 0, 20);
      n_checks++; if (out !== '0 || wrap !== 1'b1) begin n_fail++; $display("FAIL load_above_limit: got out=%0d wrap=%b expected 0 1", out, wrap); end
   endtask

   task automatic test_down_wrap();
      cycle(0, 1, 0, 0, 0, 0, 10);
      cycle(1, 0, 0, 0, 0, 0, 10);
      n_checks++; if (out !== WIDTH'(10) || wrap !== 1'b1) begin n_fail++; $display("FAIL down_wrap: got out=%0d wrap=%b expected 10 1", out, wrap); end
      while (m_state == S_CALC) cycle(1, 0, 0, 0, 0, 0, 10);
      n_checks++; if (div_hit !== exp_hit() || ready !== 1'b1) begin n_fail++; $display("FAIL down_wrap residue: got hit=%b ready=%b expected %b 1", div_hit, ready, exp_hit()); end
      cycle(1, 0, 0, 0, 0, 0, 10);
      n_checks++; if (out !== WIDTH'(9) || div_hit !== exp_hit()) begin n_fail++; $display("FAIL down_step: got out=%0d hit=%b expected 9 %b", out, div_hit, exp_hit()); end
   endtask

   task automatic test_oneshot();
      cycle(0, 1, 0, 0, 1, 1, 5);
      repeat (6) cycle(1, 0, 0, 0, 1, 1, 5);
      n_checks++; if (out !== WIDTH'(5) || done !== 1'b1 || wrap !== 1'b0) begin
         n_fail++; $display("FAIL oneshot halt: got out=%0d done=%b wrap=%b expected 5 1 0", out, done, wrap);
      end
      repeat (3) cycle(1, 0, 0, 0, 1, 0, 5);
      n_checks++; if (out !== WIDTH'(5) || done !== 1'b1 || ready !== 1'b0) begin
         n_fail++; $display("FAIL oneshot stay: got out=%0d done=%b ready=%b expected 5 1 0", out, done, ready);
      end
      cycle(0, 0, 1, 2, 1, 1, 5);
      while (m_state == S_CALC) cycle(0, 0, 0, 0, 1, 1, 5);
      n_checks++; if (out !== WIDTH'(2) || done !== 1'b0 || ready !== 1'b1) begin
         n_fail++; $display("FAIL oneshot reload: got out=%0d done=%b ready=%b expected 2 0 1", out, done, ready);
      end
   endtask

   task automatic test_clr_load_reset();
      cycle(0, 0, 1, 1000, 1, 0, 0);
      repeat (4) cycle(0, 0, 0, 0, 1, 0, 0);
      cycle(0, 1, 1, 777, 1, 0, 0);
      n_checks++; if (out !== '0 || ready !== 1'b1 || div_valid !== exp_valid()) begin
         n_fail++; $display("FAIL clr_over_load: got out=%0d ready=%b valid=%b expected 0 1 %b", out, ready, div_valid, exp_valid());
      end
      cycle(0, 0, 1, 1000, 1, 0, 0);
      repeat (3) cycle(0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      load = 1'b0;
      rstn = 1'b0;
      model_reset();
      #1;
      n_checks++; if (out !== '0 || ready !== 1'b1 || done !== 1'b0 || div_valid !== exp_valid() || div_hit !== exp_hit()) begin
         n_fail++; $display("FAIL async_reset: got out=%0d ready=%b done=%b valid=%b hit=%b", out, ready, done, div_valid, div_hit);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_random();
      bit e, c, ld, d, os;
      int lv, lim;
      d = 1'b1; os = 1'b0; lim = 12;
      for (int i = 0; i < 600; i++) begin
         c  = ($urandom_range(0, 99) < 3);
         ld = ($urandom_range(0, 99) < 6);
         e  = ($urandom_range(0, 99) < 80);
         lv = $urandom_range(0, 40);
         if ($urandom_range(0, 9) == 0) d = ~d;
         if ($urandom_range(0, 19) == 0) os = ~os;
         if ($urandom_range(0, 29) == 0) lim = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 25);
         cycle(e, c, ld, lv, d, os, lim);
         n_checks++;
         if (out !== WIDTH'(m_out) || wrap !== m_wrap || done !== (m_state == S_HALT) ||
             ready !== (m_state == S_RUN) || div_valid !== exp_valid() ||
             (hit_known() && div_hit !== exp_hit())) begin
            n_fail++;
            $display("FAIL random cyc %0d: got out=%0d wrap=%b done=%b ready=%b valid=%b hit=%b expected out=%0d wrap=%b state=%0d",
                     i, out, wrap, done, ready, div_valid, div_hit, m_out, m_wrap, m_state);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_load();
      test_down_wrap();
      test_oneshot();
      test_clr_load_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/param_cnt_div.md
PARAM_CNT_DIV -- requirements
Module: param_cnt_div

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter width in bits (2..32).
REQ-002 SHALL have parameter DIV, default 3, divisibility check modulus (2..255).
REQ-003 SHALL have parameter LIMIT_RST, default 300, limit value used when port limit is 0.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, count-step enable.
REQ-007 SHALL have port clr, input, 1, synchronous clear.
REQ-008 SHALL have port load, input, 1, synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH, value loaded on load.
REQ-010 SHALL have port dir, input, 1, count direction: 1 up, 0 down.
REQ-011 SHALL have port oneshot, input, 1, mode: 0 wrap, 1 halt at terminal.
REQ-012 SHALL have port limit, input, WIDTH, inclusive upper count bound; 0 selects LIMIT_RST.
REQ-013 SHALL have port out, output, WIDTH, registered count value.
REQ-014 SHALL have port wrap, output, 1, one-cycle pulse on wrap-around.
REQ-015 SHALL have port done, output, 1, high while in HALT.
REQ-016 SHALL have port ready, output, 1, high when en is accepted (state RUN).
REQ-017 SHALL have port div_hit, output, 1, out mod DIV == 0, meaningful when div_valid.
REQ-018 SHALL have port div_valid, output, 1, div_hit is current.

Function
REQ-019 SHALL implement states RUN, CALC, HALT; one command acts per cycle, priority clr > load > en.
REQ-020 SHALL, on clr in any state: out=0, residue=0, enter RUN, done=0, next cycle.
REQ-021 SHALL, on load in any state: out=load_val next cycle, enter CALC (macro on) or RUN (macro off).
REQ-022 SHALL, in RUN with en and dir=1: out+1 if out<L (L = effective limit), else out=0 with wrap=1.
REQ-023 SHALL, in RUN with en and dir=0: out-1 if out>0, else out=L with wrap=1 and enter CALC (macro on).
REQ-024 SHALL treat load_val>L as legal; the next up-step wraps to 0 with wrap=1.
REQ-025 SHALL, with oneshot=1, replace a wrapping step by entering HALT with out unchanged and wrap=0.
REQ-026 SHALL ignore en in CALC and HALT; ready=0 in those states.
REQ-027 SHALL leave HALT only on clr or load; toggling oneshot in HALT has no effect.
REQ-028 SHALL track residue = out mod DIV incrementally: +1 mod DIV up, -1 mod DIV down, 0 on up-wrap; no divide/modulo operator.
REQ-029 SHALL, in CALC, compute residue serially MSB first, r=(2r+bit) mod DIV, one bit per cycle, exactly WIDTH cycles, then enter RUN.
REQ-030 SHALL hold div_valid=0 during CALC and 1 otherwise; div_hit = (residue==0) combinationally.
REQ-031 SHALL sample limit every cycle; a limit change takes effect on the next step.

Reset
REQ-032 SHALL, while rstn=0, force out=0, residue=0, state RUN, wrap=0, done=0, ready=1, div_hit=1, div_valid=1.
REQ-033 SHALL abort any CALC in progress on reset assertion without a partial result.

Configuration
REQ-034 SHALL, with macro CNT_DIV_CHK_EN defined, include the residue tracker and CALC state as above.
REQ-035 SHALL, without CNT_DIV_CHK_EN, omit residue and CALC; div_hit=0, div_valid=0 constant; load and down-wrap go straight to RUN.

Verification
REQ-036 SHALL check: defaults, limit=0, dir=1, en=1 for 302 cycles -> out 0..300 then 0, one wrap pulse, div_hit at 0,3,...,300.
REQ-037 SHALL check: load_val=1000, WIDTH=16 -> 16 cycles div_valid=0, ready=0, then div_hit=0 (1000 mod 3=1); en ignored meanwhile.
REQ-038 SHALL check: limit=10, dir=0, out=0, en -> out=10, wrap=1, CALC 16 cycles, then div_hit=0; next steps 9 -> div_hit=1.
REQ-039 SHALL check: oneshot=1, limit=5, up from 0 -> out halts at 5, done=1, no wrap; load_val=2 -> RUN after CALC.
REQ-040 SHALL check: clr and load same cycle mid-CALC -> out=0, RUN, div_valid=1 next cycle; rstn pulse mid-CALC -> REQ-032 values.
REQ-041 SHALL check: build without CNT_DIV_CHK_EN -> load effective in 1 cycle, ready stays 1, div_hit/div_valid stay 0.
